// File: rtl/vga_timing_pkg.sv
// Shared types and timing helpers for the scaled VGA timing generator.
// Axis durations, region encoding and the delayed video control bundle.
package vga_timing_pkg;

  typedef enum logic [3:0] {
    REG_DISPLAY = 4'b0001,
    REG_FRONT   = 4'b0010,
    REG_SYNC    = 4'b0100,
    REG_BACK    = 4'b1000
  } region_e;

  typedef struct packed {
    logic [15:0] display;
    logic [15:0] front;
    logic [15:0] sync;
    logic [15:0] back;
  } axis_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    logic fstart;
    logic lstart;
  } vid_t;

  function automatic int axis_total(input axis_t a);
    return int'(a.display) + int'(a.front) + int'(a.sync) + int'(a.back);
  endfunction

  function automatic int sync_start(input axis_t a);
    return int'(a.display) + int'(a.front);
  endfunction

  function automatic int sync_end(input axis_t a);
    return int'(a.display) + int'(a.front) + int'(a.sync);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counter from display start through front/sync/back.
// Wrap is a pulse qualified by the advance strobe.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int D     = 640,
  parameter int F     = 16,
  parameter int S     = 96,
  parameter int B     = 48,
  parameter int CNT_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  output logic [CNT_W-1:0] cnt_o,
  output region_e          region_o,
  output logic             wrap_o,
  output logic             active_o
);

  localparam axis_t AX = '{
    display: 16'(D), front: 16'(F), sync: 16'(S), back: 16'(B)
  };
  localparam logic [CNT_W-1:0] LAST = CNT_W'(axis_total(AX) - 1);
  localparam logic [CNT_W-1:0] FP0  = CNT_W'(D);
  localparam logic [CNT_W-1:0] SY0  = CNT_W'(sync_start(AX));
  localparam logic [CNT_W-1:0] BP0  = CNT_W'(sync_end(AX));

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = adv_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (adv_i) cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    region_o = REG_BACK;
    unique case (1'b1)
      (cnt_q < FP0):                 region_o = REG_DISPLAY;
      (cnt_q >= FP0 && cnt_q < SY0): region_o = REG_FRONT;
      (cnt_q >= SY0 && cnt_q < BP0): region_o = REG_SYNC;
      default:                       region_o = REG_BACK;
    endcase
  end

  assign active_o = (region_o == REG_DISPLAY);
  assign cnt_o    = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_scaled_timing_gen.sv
// VGA timing with integer zoom address generation and sync/blank
// delayed to line up with frame-buffer read data.
module vga_scaled_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_DISPLAY    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int SYNC_ACT_LOW = 1,
  parameter int ZOOM         = 2,
  parameter int RD_LATENCY   = 1,
  parameter int ADDR_W       = 17,
  parameter int CNT_W        = 11
) (
  input  logic              piul1Clock,
  input  logic              piul1Reset_n,
  input  logic              piul1Enable,
  output logic              poul1HSync,
  output logic              poul1VSync,
  output logic              poul1Blank_n,
  output logic              poul1FrameStart,
  output logic              poul1LineStart,
  output logic [ADDR_W-1:0] poulRAddr,
  output logic              poul1RAddrValid,
  output logic [CNT_W-1:0]  poulXPos,
  output logic [CNT_W-1:0]  poulYPos
);

  localparam int L = 1 + RD_LATENCY;
  localparam logic [1:0] ZM1 = 2'(ZOOM - 1);
  localparam logic [ADDR_W-1:0] LSTEP = ADDR_W'(H_DISPLAY / ZOOM);
  localparam logic POL = (SYNC_ACT_LOW != 0);
  localparam vid_t IDLE = '{
    hsync: POL, vsync: POL, blank_n: 1'b0, fstart: 1'b0, lstart: 1'b0
  };

  logic [CNT_W-1:0] h_cnt, v_cnt;
  region_e h_reg, v_reg;
  logic h_wrap, v_wrap, h_act, v_act, active;

  vga_axis_counter #(
    .D(H_DISPLAY), .F(H_FRONT), .S(H_SYNC), .B(H_BACK), .CNT_W(CNT_W)
  ) u_h (
    .clk_i(piul1Clock), .rst_ni(piul1Reset_n), .adv_i(piul1Enable),
    .cnt_o(h_cnt), .region_o(h_reg), .wrap_o(h_wrap), .active_o(h_act)
  );

  vga_axis_counter #(
    .D(V_DISPLAY), .F(V_FRONT), .S(V_SYNC), .B(V_BACK), .CNT_W(CNT_W)
  ) u_v (
    .clk_i(piul1Clock), .rst_ni(piul1Reset_n), .adv_i(h_wrap),
    .cnt_o(v_cnt), .region_o(v_reg), .wrap_o(v_wrap), .active_o(v_act)
  );

  assign active = h_act && v_act;

  logic [CNT_W-1:0]  sx_q, sx_d;
  logic [1:0]        px_q, px_d, ln_q, ln_d;
  logic [ADDR_W-1:0] base_q, base_d, raddr_q, raddr_d;
  logic              valid_q, valid_d;

  // Repeat counters replace division: source X and line base step once per ZOOM
  always_comb begin
    sx_d    = sx_q;
    px_d    = px_q;
    ln_d    = ln_q;
    base_d  = base_q;
    raddr_d = raddr_q;
    valid_d = valid_q;
    if (piul1Enable) begin
      valid_d = active;
      if (active) begin
        raddr_d = base_q + ADDR_W'(sx_q);
        if (px_q == ZM1) begin
          px_d = '0;
          sx_d = sx_q + 1'b1;
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      if (h_wrap) begin
        sx_d = '0;
        px_d = '0;
        if (v_act) begin
          if (ln_q == ZM1) begin
            ln_d   = '0;
            base_d = base_q + LSTEP;
          end else begin
            ln_d = ln_q + 1'b1;
          end
        end
      end
      if (v_wrap) begin
        base_d = '0;
        ln_d   = '0;
      end
    end
  end

  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      sx_q    <= '0;
      px_q    <= '0;
      ln_q    <= '0;
      base_q  <= '0;
      raddr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      px_q    <= px_d;
      ln_q    <= ln_d;
      base_q  <= base_d;
      raddr_q <= raddr_d;
      valid_q <= valid_d;
    end
  end

  vid_t [L-1:0] pipe_q, pipe_d;
  vid_t         vin;

  always_comb begin
    vin         = IDLE;
    vin.hsync   = (h_reg == REG_SYNC) ^ POL;
    vin.vsync   = (v_reg == REG_SYNC) ^ POL;
    vin.blank_n = active;
    vin.fstart  = active && (h_cnt == '0) && (v_cnt == '0);
    vin.lstart  = active && (h_cnt == '0);
    pipe_d      = pipe_q;
    if (piul1Enable) begin
      pipe_d[0] = vin;
      for (int i = 1; i < L; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) pipe_q <= {L{IDLE}};
    else               pipe_q <= pipe_d;
  end

  assign poul1HSync      = pipe_q[L-1].hsync;
  assign poul1VSync      = pipe_q[L-1].vsync;
  assign poul1Blank_n    = pipe_q[L-1].blank_n;
  assign poul1FrameStart = pipe_q[L-1].fstart;
  assign poul1LineStart  = pipe_q[L-1].lstart;
  assign poulRAddr       = raddr_q;
  assign poul1RAddrValid = valid_q;
  assign poulXPos        = h_cnt;
  assign poulYPos        = v_cnt;

endmodule

// File: tb/tb_vga_scaled_timing_gen.sv
// Bench for vga_scaled_timing_gen: two small-timing instances (zoom 2 / zoom 1)
// checked against an arithmetic model indexed by enabled-clock count.
module tb_vga_scaled_timing_gen;

  typedef struct {
    int hd, hf, hsw, hb, vd, vf, vsw, vb, z, al, lat;
  } cfg_t;

  typedef struct packed {
    logic hs, vs, bn, fs, ls, av;
    logic [16:0] addr;
    logic [10:0] x, y;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic hs1, vs1, bn1, fs1, ls1, av1, hs2, vs2, bn2, fs2, ls2, av2;
  logic [16:0] ad1, ad2;
  logic [10:0] x1, y1, x2, y2;

  int errors = 0;
  int checks = 0;
  int n = 0;
  int la1 = 0;
  int la2 = 0;
  cfg_t c1, c2;
  obs_t o1, o2;

  always #5 clk = ~clk;

  vga_scaled_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACT_LOW(1), .ZOOM(2), .RD_LATENCY(1), .ADDR_W(17), .CNT_W(11)
  ) dut (
    .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1Enable(en),
    .poul1HSync(hs1), .poul1VSync(vs1), .poul1Blank_n(bn1),
    .poul1FrameStart(fs1), .poul1LineStart(ls1),
    .poulRAddr(ad1), .poul1RAddrValid(av1),
    .poulXPos(x1), .poulYPos(y1)
  );

  vga_scaled_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACT_LOW(0), .ZOOM(1), .RD_LATENCY(3), .ADDR_W(17), .CNT_W(11)
  ) dut2 (
    .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1Enable(en),
    .poul1HSync(hs2), .poul1VSync(vs2), .poul1Blank_n(bn2),
    .poul1FrameStart(fs2), .poul1LineStart(ls2),
    .poulRAddr(ad2), .poul1RAddrValid(av2),
    .poulXPos(x2), .poulYPos(y2)
  );

  assign o1 = {hs1, vs1, bn1, fs1, ls1, av1, ad1, x1, y1};
  assign o2 = {hs2, vs2, bn2, fs2, ls2, av2, ad2, x2, y2};

  function automatic void pos(input cfg_t c, input int k,
                              output int h, output int v);
    int ht, vt, p;
    ht = c.hd + c.hf + c.hsw + c.hb;
    vt = c.vd + c.vf + c.vsw + c.vb;
    p  = k % (ht * vt);
    h  = p % ht;
    v  = p / ht;
  endfunction

  function automatic bit act(input cfg_t c, input int k);
    int h, v;
    pos(c, k, h, v);
    return (h < c.hd) && (v < c.vd);
  endfunction

  function automatic int addr_of(input cfg_t c, input int k);
    int h, v;
    pos(c, k, h, v);
    return (v / c.z) * (c.hd / c.z) + h / c.z;
  endfunction

  function automatic obs_t model(input cfg_t c, input int k, input int la);
    obs_t e;
    int h, v;
    bit a, hin, vin;
    pos(c, k, h, v);
    e.x    = 11'(h);
    e.y    = 11'(v);
    e.av   = (k >= 1) && act(c, k - 1);
    e.addr = 17'(la);
    if (k >= c.lat + 1) begin
      pos(c, k - c.lat - 1, h, v);
      a    = (h < c.hd) && (v < c.vd);
      hin  = (h >= c.hd + c.hf) && (h < c.hd + c.hf + c.hsw);
      vin  = (v >= c.vd + c.vf) && (v < c.vd + c.vf + c.vsw);
      e.bn = a;
      e.hs = hin ^ (c.al != 0);
      e.vs = vin ^ (c.al != 0);
      e.fs = a && (h == 0) && (v == 0);
      e.ls = a && (h == 0);
    end else begin
      e.bn = 1'b0;
      e.hs = (c.al != 0);
      e.vs = (c.al != 0);
      e.fs = 1'b0;
      e.ls = 1'b0;
    end
    return e;
  endfunction

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    if (rst_n && e) begin
      if (act(c1, n)) la1 = addr_of(c1, n);
      if (act(c2, n)) la2 = addr_of(c2, n);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    obs_t r1, r2;
    rst_n = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clk);
    r1 = {1'b1, 1'b1, 4'b0, 17'd0, 11'd0, 11'd0};
    r2 = '0;
    checks++;
    if (o1 !== r1) begin
      errors++;
      $display("FAIL reset_dut1 got=%h exp=%h", o1, r1);
    end
    checks++;
    if (o2 !== r2) begin
      errors++;
      $display("FAIL reset_dut2 got=%h exp=%h", o2, r2);
    end
    rst_n = 1'b1;
    n = 0;
    la1 = 0;
    la2 = 0;
  endtask

  task automatic test_frame;
    int fsn[$];
    int aq1[$];
    int aq2[$];
    int exp_seq[32] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3,
                        4, 4, 5, 5, 6, 6, 7, 7, 4, 4, 5, 5, 6, 6, 7, 7};
    int hl = 0, vl = 0, bc = 0, fc = 0;
    bit bad;
    obs_t e;
    for (int i = 0; i < 210; i++) begin
      step(1'b1);
      e = model(c1, n, la1);
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL frame_dut1 n=%0d got=%h exp=%h", n, o1, e);
      end
      e = model(c2, n, la2);
      checks++;
      if (o2 !== e) begin
        errors++;
        $display("FAIL frame_dut2 n=%0d got=%h exp=%h", n, o2, e);
      end
      if (n >= 2 && n < 100) begin
        if (!hs1) hl++;
        if (!vs1) vl++;
        if (bn1) bc++;
        if (fs1) fc++;
      end
      if (n >= 1 && n <= 98 && av1) aq1.push_back(int'(ad1));
      if (n >= 1 && n <= 98 && av2) aq2.push_back(int'(ad2));
      if (fs1) fsn.push_back(n);
    end
    checks++;
    if (hl != 14 || vl != 14) begin
      errors++;
      $display("FAIL sync_width hlow=%0d vlow=%0d exp=14/14", hl, vl);
    end
    checks++;
    if (bc != 32 || fc != 1) begin
      errors++;
      $display("FAIL blank_count blank=%0d fs=%0d exp=32/1", bc, fc);
    end
    bad = (aq1.size() != 32);
    if (!bad) foreach (exp_seq[i]) if (aq1[i] != exp_seq[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL zoom2_seq got=%p exp=%p", aq1, exp_seq);
    end
    checks++;
    if (aq1.size() == 0 || aq1[aq1.size()-1] != 7) begin
      errors++;
      $display("FAIL last_addr size=%0d exp last=7", aq1.size());
    end
    bad = (aq2.size() != 32);
    if (!bad) foreach (aq2[i]) if (aq2[i] != i) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL zoom1_seq got=%p exp=0..31", aq2);
    end
    checks++;
    if (fsn.size() != 3 || fsn[0] != 2 || fsn[1] - fsn[0] != 98
        || fsn[2] - fsn[1] != 98) begin
      errors++;
      $display("FAIL fs_period got=%p exp=2,100,198", fsn);
    end
  endtask

  task automatic test_enable_hold;
    int fsn[$];
    int guard = 0;
    obs_t s1, s2, e;
    while (!((n % 98) == 31 && fsn.size() >= 1) && guard < 300) begin
      step(1'b1);
      if (fs1) fsn.push_back(n);
      guard++;
    end
    checks++;
    if (guard >= 300 || x1 !== 11'd3 || y1 !== 11'd2) begin
      errors++;
      $display("FAIL hold_pos x=%0d y=%0d exp=3/2 guard=%0d", x1, y1, guard);
    end
    s1 = o1;
    s2 = o2;
    repeat (5) begin
      step(1'b0);
      checks++;
      if (o1 !== s1 || o2 !== s2) begin
        errors++;
        $display("FAIL hold_frozen got=%h/%h exp=%h/%h", o1, o2, s1, s2);
      end
    end
    guard = 0;
    while (fsn.size() < 2 && guard < 300) begin
      step(1'b1);
      e = model(c1, n, la1);
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL resume_dut1 n=%0d got=%h exp=%h", n, o1, e);
      end
      e = model(c2, n, la2);
      checks++;
      if (o2 !== e) begin
        errors++;
        $display("FAIL resume_dut2 n=%0d got=%h exp=%h", n, o2, e);
      end
      if (fs1) fsn.push_back(n);
      guard++;
    end
    checks++;
    if (fsn.size() < 2 || fsn[1] - fsn[0] != 98) begin
      errors++;
      $display("FAIL hold_frame_len got=%p exp=98 apart", fsn);
    end
  endtask

  task automatic test_random;
    obs_t e;
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 3) != 0));
      e = model(c1, n, la1);
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL rand_dut1 n=%0d got=%h exp=%h", n, o1, e);
      end
      e = model(c2, n, la2);
      checks++;
      if (o2 !== e) begin
        errors++;
        $display("FAIL rand_dut2 n=%0d got=%h exp=%h", n, o2, e);
      end
    end
  endtask

  task automatic test_async_reset;
    obs_t r1, r2, e;
    r1 = {1'b1, 1'b1, 4'b0, 17'd0, 11'd0, 11'd0};
    r2 = '0;
    repeat (37) step(1'b1);
    @(posedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    checks++;
    if (o1 !== r1 || o2 !== r2) begin
      errors++;
      $display("FAIL async_reset got=%h/%h exp=%h/%h", o1, o2, r1, r2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    la1 = 0;
    la2 = 0;
    step(1'b1);
    step(1'b1);
    checks++;
    if (fs1 !== 1'b1 || ls1 !== 1'b1 || ad1 !== 17'd0 || av1 !== 1'b1) begin
      errors++;
      $display("FAIL first_frame fs=%b ls=%b addr=%0d v=%b exp=1/1/0/1",
               fs1, ls1, ad1, av1);
    end
    for (int i = 0; i < 120; i++) begin
      step(1'b1);
      e = model(c1, n, la1);
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL post_reset_dut1 n=%0d got=%h exp=%h", n, o1, e);
      end
      e = model(c2, n, la2);
      checks++;
      if (o2 !== e) begin
        errors++;
        $display("FAIL post_reset_dut2 n=%0d got=%h exp=%h", n, o2, e);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    c1 = '{8, 2, 2, 2, 4, 1, 1, 1, 2, 1, 1};
    c2 = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 0, 3};
    test_reset();
    test_frame();
    test_enable_hold();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
